// File: rtl/matrix_requant.sv
// Requantizes the multiplier's 32-bit result banks row by row into signed 16-bit rows.
// Define MATRIX_REQUANT_RELU_EN to clamp negative results to zero after saturation.
module matrix_requant #(
  parameter int CNT    = 64,
  parameter int BIT    = $clog2(CNT),
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_in,
  input  logic                mult_rdy_in,
  input  logic [BIT:0]        rows_in,
  input  logic [4:0]          shift_in,
  output logic                busy_out,
  output logic                done_out,
  output logic                sat_flag_out,
  output logic [BIT-1:0]      addrb_out,
  input  logic [CNT*32-1:0]   doutb_in,
  output logic                wr_en_out,
  output logic [BIT-1:0]      wr_addr_out,
  output logic [CNT*16-1:0]   wr_data_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [BIT:0] ROWS_MAX = (BIT+1)'(CNT);
  localparam logic [BIT:0] ONE_ROW  = (BIT+1)'(1);
  localparam logic [2:0]   DRAIN_LAST = 3'(RD_LAT);

  logic [1:0]          state_q, state_d;
  logic                start_r_q, start_r_d;
  logic                start_r2_q, start_r2_d;
  logic [BIT:0]        rows_q, rows_d;
  logic [4:0]          shift_q, shift_d;
  logic [BIT-1:0]      addr_q, addr_d;
  logic [2:0]          drain_q, drain_d;
  logic [RD_LAT-1:0]   vpipe_q, vpipe_d;
  logic [BIT-1:0]      apipe_q [RD_LAT];
  logic [BIT-1:0]      apipe_d [RD_LAT];
  logic                wr_en_q, wr_en_d;
  logic [BIT-1:0]      wr_addr_q, wr_addr_d;
  logic [CNT*16-1:0]   wr_data_q, wr_data_d;
  logic                sat_q, sat_d;

  logic                start_edge;
  logic                issue;
  logic [BIT:0]        rows_clamped;
  logic [CNT*16-1:0]   rq_row;
  logic [CNT-1:0]      sat_vec;

  // Round half-up, arithmetic shift, saturate; returns {saturated, value}.
  function automatic logic [16:0] requant_elem(input logic [31:0] x, input logic [4:0] s);
    logic signed [32:0] ext;
    logic signed [32:0] rnd;
    logic signed [32:0] shr;
    logic [15:0]        val;
    logic               sat;
    ext = {x[31], x};
    rnd = '0;
    if (s != 5'd0) rnd = 33'sd1 <<< (s - 5'd1);
    shr = (ext + rnd) >>> s;
    sat = 1'b0;
    val = shr[15:0];
    if (shr > 33'sd32767) begin
      val = 16'h7fff;
      sat = 1'b1;
    end else if (shr < -33'sd32768) begin
      val = 16'h8000;
      sat = 1'b1;
    end
`ifdef MATRIX_REQUANT_RELU_EN
    if (val[15]) val = '0;
`endif
    return {sat, val};
  endfunction

  assign start_edge   = start_r_q & ~start_r2_q;
  assign rows_clamped = (rows_in > ROWS_MAX) ? ROWS_MAX : rows_in;

  always_comb begin
    rq_row  = '0;
    sat_vec = '0;
    for (int j = 0; j < CNT; j++) begin
      {sat_vec[j], rq_row[j*16 +: 16]} = requant_elem(doutb_in[j*32 +: 32], shift_q);
    end
  end

  always_comb begin
    start_r_d  = start_in;
    start_r2_d = start_r_q;
    state_d    = state_q;
    rows_d     = rows_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    drain_d    = drain_q;
    sat_d      = sat_q;
    issue      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_edge && mult_rdy_in) begin
          rows_d  = rows_clamped;
          shift_d = shift_in;
          sat_d   = 1'b0;
          addr_d  = '0;
          state_d = (rows_clamped == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        issue = 1'b1;
        if ({1'b0, addr_q} == rows_q - ONE_ROW) begin
          addr_d  = '0;
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = S_DONE;
        else                       drain_d = drain_q + 3'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Each issued address carries a valid bit down a RD_LAT-deep line so the
    // returning bank data can be matched to its row without any counters.
    vpipe_d[0] = issue;
    apipe_d[0] = addr_q;
    for (int i = 1; i < RD_LAT; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
      apipe_d[i] = apipe_q[i-1];
    end

    // Write port: wr_en_out is a one-cycle strobe; wr_addr_out and wr_data_out
    // are valid in exactly the cycle it is high and there is no backpressure.
    wr_en_d   = vpipe_q[RD_LAT-1];
    wr_addr_d = wr_en_d ? apipe_q[RD_LAT-1] : wr_addr_q;
    wr_data_d = wr_en_d ? rq_row : wr_data_q;
    if (wr_en_d && (|sat_vec)) sat_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      start_r_q  <= 1'b0;
      start_r2_q <= 1'b0;
      rows_q     <= '0;
      shift_q    <= '0;
      addr_q     <= '0;
      drain_q    <= '0;
      vpipe_q    <= '0;
      for (int i = 0; i < RD_LAT; i++) apipe_q[i] <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_r_q  <= start_r_d;
      start_r2_q <= start_r2_d;
      rows_q     <= rows_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      drain_q    <= drain_d;
      vpipe_q    <= vpipe_d;
      for (int i = 0; i < RD_LAT; i++) apipe_q[i] <= apipe_d[i];
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      sat_q      <= sat_d;
    end
  end

  assign busy_out     = (state_q != S_IDLE);
  assign done_out     = (state_q == S_DONE);
  assign sat_flag_out = sat_q;
  assign addrb_out    = addr_q;
  assign wr_en_out    = wr_en_q;
  assign wr_addr_out  = wr_addr_q;
  assign wr_data_out  = wr_data_q;

endmodule

// File: tb/tb_matrix_requant.sv
// Bench for matrix_requant: bank read model, reference requantizer, scoreboard monitor.
module tb_matrix_requant;
  localparam int CNT    = 64;
  localparam int BIT    = $clog2(CNT);
  localparam int RD_LAT = 1;

  logic                clk;
  logic                rst;
  logic                start_in;
  logic                mult_rdy_in;
  logic [BIT:0]        rows_in;
  logic [4:0]          shift_in;
  logic                busy_out;
  logic                done_out;
  logic                sat_flag_out;
  logic [BIT-1:0]      addrb_out;
  logic [CNT*32-1:0]   doutb_in;
  logic                wr_en_out;
  logic [BIT-1:0]      wr_addr_out;
  logic [CNT*16-1:0]   wr_data_out;

  int checks = 0;
  int errors = 0;
  longint cyc = 0;

  logic [31:0]        mem [CNT][CNT];
  logic [CNT*16-1:0]  exp_q[$];
  logic [BIT-1:0]     exp_addr_q[$];
  longint             wr_cyc_q[$];
  logic [CNT*16-1:0]  last_data;
  logic [CNT*16-1:0]  mon_exp;
  logic [BIT-1:0]     mon_addr;

  matrix_requant #(.CNT(CNT), .BIT(BIT), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .mult_rdy_in(mult_rdy_in),
    .rows_in(rows_in), .shift_in(shift_in), .busy_out(busy_out),
    .done_out(done_out), .sat_flag_out(sat_flag_out), .addrb_out(addrb_out),
    .doutb_in(doutb_in), .wr_en_out(wr_en_out), .wr_addr_out(wr_addr_out),
    .wr_data_out(wr_data_out)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // result-bank model: registered read, RD_LAT cycles
  logic [CNT*32-1:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    for (int j = 0; j < CNT; j++) rd_pipe[0][j*32 +: 32] <= mem[addrb_out][j];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign doutb_in = rd_pipe[RD_LAT-1];

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  // reference: round(x / 2^s) half-up via floor division, then clamp
  function automatic logic [15:0] ref_requant(input int x, input int s, output bit sat);
    longint v, d, q;
    v = x;
    d = longint'(1) << s;
    if (s > 0) v = v + d / 2;
    q = v / d;
    if ((v % d) != 0 && v < 0) q = q - 1;
    sat = 1'b0;
    if (q > 32767) begin q = 32767; sat = 1'b1; end
    else if (q < -32768) begin q = -32768; sat = 1'b1; end
`ifdef MATRIX_REQUANT_RELU_EN
    if (q < 0) q = 0;
`endif
    return q[15:0];
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (wr_en_out) begin
      wr_cyc_q.push_back(cyc);
      last_data = wr_data_out;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr %0d at cycle %0d", wr_addr_out, cyc);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_addr = exp_addr_q.pop_front();
        chk("wr_addr", wr_addr_out, mon_addr);
        checks++;
        if (wr_data_out !== mon_exp) begin
          errors++;
          for (int j = 0; j < CNT; j++) begin
            if (wr_data_out[j*16 +: 16] !== mon_exp[j*16 +: 16]) begin
              $display("FAIL wr_data row %0d col %0d got %0d expected %0d", mon_addr, j,
                       $signed(wr_data_out[j*16 +: 16]), $signed(mon_exp[j*16 +: 16]));
              break;
            end
          end
        end
      end
    end
  end

  // mode 0: full range, 1: +-65536, 2: +-30000, 3: +-10000
  task automatic fill_random(input int mode);
    for (int r = 0; r < CNT; r++)
      for (int c = 0; c < CNT; c++)
        case (mode)
          0:       mem[r][c] = $urandom;
          1:       mem[r][c] = $urandom_range(0, 131072) - 65536;
          2:       mem[r][c] = $urandom_range(0, 60000) - 30000;
          default: mem[r][c] = $urandom_range(0, 20000) - 10000;
        endcase
  endtask

  task automatic run(input int rows, input int shift, input bit hold, input bit drop_rdy);
    int reff;
    bit esat, s, busy_seen;
    logic [CNT*16-1:0] row;
    logic [BIT-1:0] a;
    longint sc, dc;
    int k;
    reff = (rows > CNT) ? CNT : rows;
    esat = 1'b0;
    for (int r = 0; r < reff; r++) begin
      for (int j = 0; j < CNT; j++) begin
        row[j*16 +: 16] = ref_requant(int'(mem[r][j]), shift, s);
        esat |= s;
      end
      a = r[BIT-1:0];
      exp_q.push_back(row);
      exp_addr_q.push_back(a);
    end
    wr_cyc_q.delete();
    @(posedge clk); #1;
    rows_in  = rows[BIT:0];
    shift_in = shift[4:0];
    start_in = 1'b1;
    sc = cyc;
    dc = -1;
    k  = 0;
    while (k < reff + 60) begin
      @(negedge clk);
      if (cyc - sc == 1 && !hold) start_in = 1'b0;
      if (cyc - sc == 2) chk("busy_running", busy_out, 1);
      if (drop_rdy && cyc - sc == 3) mult_rdy_in = 1'b0;
      if (done_out) begin dc = cyc; break; end
      k++;
    end
    if (dc < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout rows %0d got no done expected done", rows);
    end else begin
      chk("done_cycle", dc - sc, (reff > 0) ? reff + RD_LAT + 3 : 2);
    end
    @(negedge clk);
    chk("done_one_cycle", done_out, 0);
    chk("busy_after", busy_out, 0);
    chk("write_count", wr_cyc_q.size(), reff);
    if (reff > 0 && wr_cyc_q.size() == reff) begin
      chk("first_write", wr_cyc_q[0] - sc, RD_LAT + 3);
      chk("last_write", wr_cyc_q[reff-1], dc - 1);
    end
    chk("sat_flag", sat_flag_out, esat);
    chk("queue_drained", exp_q.size(), 0);
    if (hold) begin
      busy_seen = 1'b0;
      repeat (6) begin @(negedge clk); busy_seen |= busy_out; end
      chk("hold_single_run", busy_seen, 0);
      start_in = 1'b0;
    end
    mult_rdy_in = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  initial begin
    bit busy_seen;
    rst = 1'b1; start_in = 1'b0; mult_rdy_in = 1'b1; rows_in = '0; shift_in = '0;
    fill_random(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_sat", sat_flag_out, 0);
    chk("rst_wr_en", wr_en_out, 0);
    chk("rst_addrb", addrb_out, 0);
    chk("rst_wr_addr", wr_addr_out, 0);
    chk("rst_wr_data_zero", (wr_data_out == '0), 1);
    @(posedge clk); #1 rst = 1'b0;

    // pass-through rows
    for (int r = 0; r < CNT; r++) for (int c = 0; c < CNT; c++) mem[r][c] = r * 100 + c;
    run(3, 0, 0, 0);
    chk("t1_row2_col5", longint'($signed(last_data[5*16 +: 16])), 205);

    // rounding half-up
    fill_random(1);
    mem[0][0] = 24; mem[0][1] = 23; mem[0][2] = -24; mem[0][3] = -25;
    run(1, 4, 0, 0);
    chk("round_24", longint'($signed(last_data[0 +: 16])), 2);
    chk("round_23", longint'($signed(last_data[16 +: 16])), 1);
`ifndef MATRIX_REQUANT_RELU_EN
    chk("round_m24", longint'($signed(last_data[32 +: 16])), -1);
    chk("round_m25", longint'($signed(last_data[48 +: 16])), -2);
`endif

    // saturation, then sticky flag cleared by a clean run
    fill_random(2);
    mem[0][0] = 40000; mem[0][1] = -40000; mem[0][2] = 32767;
    run(1, 0, 0, 0);
    chk("sat_pos", longint'($signed(last_data[0 +: 16])), 32767);
    chk("sat_flag_set", sat_flag_out, 1);
    fill_random(2);
    run(4, 0, 0, 0);
    chk("sat_flag_cleared", sat_flag_out, 0);

    // zero rows, start held high
    run(0, 3, 0, 0);
    run(0, 3, 1, 0);
    fill_random(1);
    run(5, 2, 1, 0);

    // start edge with multiplier not ready is dropped
    @(posedge clk); #1;
    mult_rdy_in = 1'b0;
    start_in = 1'b1;
    busy_seen = 1'b0;
    repeat (6) begin @(negedge clk); busy_seen |= busy_out; end
    chk("not_ready_ignored", busy_seen, 0);
    @(posedge clk); #1 mult_rdy_in = 1'b1;
    repeat (4) begin @(negedge clk); busy_seen |= busy_out; end
    chk("late_ready_no_edge", busy_seen, 0);
    start_in = 1'b0;

    // reset during READ of an 8-row run
    fill_random(0);
    @(posedge clk); #1;
    rows_in = 8; shift_in = 3; start_in = 1'b1;
    @(posedge clk); #1 start_in = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("busy_in_read", busy_out, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_wr_en", wr_en_out, 0);
    chk("abort_busy", busy_out, 0);
    busy_seen = 1'b0;
    repeat (8) begin @(negedge clk); busy_seen |= busy_out | done_out; end
    chk("abort_quiet", busy_seen, 0);
    run(8, 3, 0, 0);

    // relu / signed behaviour
    fill_random(3);
    mem[0][0] = -6; mem[0][1] = 7; mem[0][2] = -70000;
    run(1, 1, 0, 0);
    chk("relu_case_b", longint'($signed(last_data[16 +: 16])), 4);
`ifdef MATRIX_REQUANT_RELU_EN
    chk("relu_case_a", longint'($signed(last_data[0 +: 16])), 0);
    chk("relu_case_c", longint'($signed(last_data[32 +: 16])), 0);
`else
    chk("relu_case_a", longint'($signed(last_data[0 +: 16])), -3);
    chk("relu_case_c", longint'($signed(last_data[32 +: 16])), -32768);
`endif
    chk("relu_sat_flag", sat_flag_out, 1);

    // randomized runs, including rows above CNT and ready dropping mid-run
    for (int i = 0; i < 8; i++) begin
      fill_random($urandom_range(0, 2));
      run($urandom_range(0, CNT + 3), $urandom_range(0, 31), 0, (i == 3));
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
